// File: rtl/ff_nn_layer_seq.sv
// Time-multiplexed fully-connected layer: a single signed MAC walks every
// neuron's weights in turn, then a step activation produces one bit per neuron.
module ff_nn_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 8,
  parameter int WW    = 8,
  localparam int AW    = $clog2(N_OUT*(N_IN+1)),
  localparam int ACC_W = XW+WW+$clog2(N_IN+1)+1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_IN*XW-1:0]      x_flat,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic [WW-1:0]           w_data,
  output logic [N_OUT-1:0]        y,
  output logic signed [ACC_W-1:0] acc_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              fsm_state
);

  localparam int NCOEF = N_OUT*(N_IN+1);
  localparam int KW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [KW-1:0]            k;
  logic [JW-1:0]            j;
  logic [N_IN*XW-1:0]       x_reg;
  logic signed [WW-1:0]     coef [NCOEF];
  logic signed [ACC_W-1:0]  acc, prod, sum_base, sum_next;
  logic [XW-1:0]            xk;
  logic signed [WW-1:0]     wk, bj;
  logic [AW-1:0]            w_idx, b_idx;
  logic                     last_k, last_j, coef_wr_ok;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and the producer holds its data
  // stable while valid is high and ready is low.

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = COMPUTE;
      COMPUTE: if (last_k && last_j) state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    fsm_state = state;
  end

  // Operand fetch and MAC; the k==0 step seeds the sum with the bias.
  always_comb begin
    w_idx    = AW'(int'(j)*(N_IN+1) + int'(k));
    b_idx    = AW'(int'(j)*(N_IN+1) + N_IN);
    xk       = x_reg[XW*k +: XW];
    wk       = coef[w_idx];
    bj       = coef[b_idx];
    prod     = ACC_W'(signed'({1'b0, xk})) * ACC_W'(wk);
    sum_base = (k == '0) ? ACC_W'(bj) : acc;
    sum_next = sum_base + prod;
    last_k   = (k == KW'(N_IN-1));
    last_j   = (j == JW'(N_OUT-1));
    coef_wr_ok = w_we && (state != COMPUTE) && (int'(w_addr) < NCOEF);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_reg    <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      y        <= '0;
      acc_last <= '0;
      for (int n = 0; n < NCOEF; n++) coef[n] <= '0;
    end else begin
      if (coef_wr_ok) coef[w_addr] <= w_data;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x_flat;
            j     <= '0;
            k     <= '0;
          end
        end
        COMPUTE: begin
          acc <= sum_next;
          if (last_k) begin
            for (int n = 0; n < N_OUT; n++)
              if (n == int'(j)) y[n] <= (sum_next > 0);
            if (last_j) acc_last <= sum_next;
            k <= '0;
            j <= j + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
